// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM states and the baud/oversample derivation.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OS_RATE = 16;  // oversample ticks per bit
  localparam int OS_MID  = 7;   // tick index used as the mid-bit sample point

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;

  function automatic int calc_os_div(input int clock_hz, input int baud_hz);
    return clock_hz / (OS_RATE * baud_hz);
  endfunction

  function automatic int calc_bit_clks(input int clock_hz, input int baud_hz);
    return OS_RATE * calc_os_div(clock_hz, baud_hz);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every OS_DIV clocks, phase reset by restart.
module uart_baud_gen #(
  parameter int OS_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || restart || cnt == CW'(OS_DIV - 1)) cnt <= '0;
    else                                            cnt <= cnt + 1'b1;
  end

  // Suppressed in the restart cycle so the first tick lands OS_DIV clocks later.
  assign tick = !restart && (cnt == CW'(OS_DIV - 1));
endmodule

// File: rtl/uart_framed.sv
// Framed UART: parameterised data/parity/stop TX and oversampled RX with a one-deep output holding register.
module uart_framed
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 1_000_000,
  parameter int BAUD_HZ   = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_tx,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int   OS_DIV  = calc_os_div(CLOCK_HZ, BAUD_HZ);
  localparam logic PAR_EN  = (PARITY != PAR_NONE);
  localparam logic PAR_INV = (PARITY == PAR_ODD);

  if (OS_DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_framed: illegal parameter set");
  end

  // ---------------- transmitter ----------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [3:0]           tx_os_q, tx_os_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_line_d, tx_restart, tx_tick, tx_bit_end;

  uart_baud_gen #(.OS_DIV(OS_DIV)) u_tx_baud (
    .clock(clock), .reset(reset), .restart(tx_restart), .tick(tx_tick)
  );

  assign tx_ready   = (tx_state_q == ST_IDLE);
  assign tx_bit_end = tx_tick && (tx_os_q == 4'(OS_RATE - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_restart = 1'b0;
    tx_line_d  = 1'b1;
    if (tx_tick) tx_os_d = tx_os_q + 4'd1;
    case (tx_state_q)
      ST_IDLE: begin
        tx_os_d  = '0;
        tx_bit_d = '0;
        if (tx_valid) begin
          tx_state_d = ST_START;
          tx_shift_d = tx_data;
          tx_par_d   = ^tx_data ^ PAR_INV;
          tx_restart = 1'b1;
        end
      end
      ST_START: if (tx_bit_end) tx_state_d = ST_DATA;
      ST_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == 4'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
        end else tx_bit_d = tx_bit_q + 4'd1;
      end
      ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
      ST_STOP: if (tx_bit_end) begin
        if (tx_bit_q == 4'(STOP_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = ST_IDLE;
        end else tx_bit_d = tx_bit_q + 4'd1;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Line is registered from the next state so it changes together with the FSM.
    case (tx_state_d)
      ST_START:  tx_line_d = 1'b0;
      ST_DATA:   tx_line_d = tx_shift_d[0];
      ST_PARITY: tx_line_d = tx_par_d;
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      serial_tx  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      serial_tx  <= tx_line_d;
    end
  end

  // ---------------- receiver ----------------
  uart_state_e          rx_state_q, rx_state_d;
  logic [3:0]           rx_os_q, rx_os_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev, rx_par_q, rx_par_d;
  logic                 rx_restart, rx_tick, rx_sample, rx_bit_end, rx_done;

  uart_baud_gen #(.OS_DIV(OS_DIV)) u_rx_baud (
    .clock(clock), .reset(reset), .restart(rx_restart), .tick(rx_tick)
  );

  assign rx_s       = rx_sync[1];
  assign rx_sample  = rx_tick && (rx_os_q == 4'(OS_MID));
  assign rx_bit_end = rx_tick && (rx_os_q == 4'(OS_RATE - 1));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_restart = 1'b0;
    rx_done    = 1'b0;
    if (rx_tick) rx_os_d = rx_os_q + 4'd1;
    case (rx_state_q)
      ST_IDLE: begin
        rx_os_d  = '0;
        rx_bit_d = '0;
        if (rx_prev && !rx_s) begin
          rx_state_d = ST_START;
          rx_restart = 1'b1;
          rx_par_d   = 1'b0;
        end
      end
      ST_START: begin
        if (rx_sample && rx_s) rx_state_d = ST_IDLE;  // glitch, not a start bit
        else if (rx_bit_end)   rx_state_d = ST_DATA;
      end
      ST_DATA: begin
        if (rx_sample) rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_bit_q == 4'(DATA_BITS - 1)) begin
            rx_bit_d   = '0;
            rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else rx_bit_d = rx_bit_q + 4'd1;
        end
      end
      ST_PARITY: begin
        if (rx_sample)  rx_par_d   = ^rx_shift_q ^ rx_s ^ PAR_INV;
        if (rx_bit_end) rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_sample) begin
        rx_done    = 1'b1;
        rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync       <= 2'b11;
      rx_prev       <= 1'b1;
      rx_state_q    <= ST_IDLE;
      rx_os_q       <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], serial_rx};
      rx_prev    <= rx_s;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_overrun <= rx_done && rx_valid && !rx_ready;
      if (rx_done && (!rx_valid || rx_ready)) begin
        rx_data       <= rx_shift_q;
        rx_parity_err <= rx_par_q & PAR_EN;
        rx_frame_err  <= !rx_s;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_framed.sv
// Directed bench: 8N1 instance for TX timing and RX error cases, 8E1 instance for parity loopback.
module tb_uart_framed;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data0 = '0, tx_data1 = '0;
  logic       tx_valid0 = 0, tx_valid1 = 0, rx_ready0 = 0, rx_ready1 = 0;
  logic       line0 = 1'b1, line1 = 1'b1, loop1 = 1'b1;
  logic       tx_ready0, tx_ready1, stx0, stx1, srx1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1;
  int         vectors = 0, errors = 0, ovr_cnt = 0;

  always #5 clock = ~clock;
  assign srx1 = loop1 ? stx1 : line1;

  uart_framed #(.CLOCK_HZ(16_000_000), .BAUD_HZ(1_000_000), .PARITY(0)) dut0 (
    .clock(clock), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .serial_tx(stx0), .serial_rx(line0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_overrun(ovr0));

  uart_framed #(.CLOCK_HZ(16_000_000), .BAUD_HZ(1_000_000), .PARITY(1)) dut1 (
    .clock(clock), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .serial_tx(stx1), .serial_rx(srx1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overrun(ovr1));

  always @(negedge clock) if (ovr0 === 1'b1) ovr_cnt++;

  // Drives one 16-clock bit on the chosen bench line; caller is negedge-aligned.
  task automatic drive_bit(input int which, input logic b);
    if (which == 0) line0 = b; else line1 = b;
    repeat (16) @(negedge clock);
  endtask

  task automatic send_rx(input int which, input logic [7:0] d, input logic has_par,
                         input logic par, input logic stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, par);
    drive_bit(which, stop);
    if (which == 0) line0 = 1'b1; else line1 = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    vectors++; if (stx0 !== 1'b1) begin errors++; $display("FAIL reset_serial_tx got %b want 1", stx0); end
    vectors++; if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready0); end
    vectors++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid0); end
    vectors++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data0); end
    vectors++; if ({perr0, ferr0, ovr0} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b want 000", {perr0, ferr0, ovr0}); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_tx_8n1;
    logic [7:0] d;
    logic       exp_line, exp_rdy;
    d = 8'hA5;
    tx_data0 = d; tx_valid0 = 1'b1;
    @(negedge clock);
    tx_valid0 = 1'b0;
    for (int k = 1; k <= 161; k++) begin
      exp_rdy  = (k == 161);
      exp_line = (k <= 16) ? 1'b0 : (k <= 144) ? d[(k - 17) / 16] : 1'b1;
      vectors++;
      if (stx0 !== exp_line || tx_ready0 !== exp_rdy) begin
        errors++;
        $display("FAIL tx_8n1 clk %0d got line=%b rdy=%b want line=%b rdy=%b", k, stx0, tx_ready0, exp_line, exp_rdy);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_parity_loopback;
    int waited;
    tx_data1 = 8'h07; tx_valid1 = 1'b1;
    @(negedge clock);
    tx_valid1 = 1'b0;
    for (int k = 1; k < 152; k++) @(negedge clock);
    vectors++; if (stx1 !== 1'b1) begin errors++; $display("FAIL tx_parity_bit got %b want 1", stx1); end
    waited = 0;
    while (rx_valid1 !== 1'b1 && waited < 80) begin @(negedge clock); waited++; end
    vectors++; if (rx_valid1 !== 1'b1) begin errors++; $display("FAIL loop_rx_valid timeout got %b want 1", rx_valid1); end
    vectors++; if (rx_data1 !== 8'h07) begin errors++; $display("FAIL loop_rx_data got %h want 07", rx_data1); end
    vectors++; if (perr1 !== 1'b0) begin errors++; $display("FAIL loop_parity_err got %b want 0", perr1); end
    rx_ready1 = 1'b1; @(negedge clock); rx_ready1 = 1'b0;
    vectors++; if (rx_valid1 !== 1'b0) begin errors++; $display("FAIL loop_consume got %b want 0", rx_valid1); end
    repeat (20) @(negedge clock);
    loop1 = 1'b0;
    send_rx(1, 8'h07, 1'b1, 1'b0, 1'b1);
    vectors++; if (rx_valid1 !== 1'b1) begin errors++; $display("FAIL bad_par_valid got %b want 1", rx_valid1); end
    vectors++; if (rx_data1 !== 8'h07) begin errors++; $display("FAIL bad_par_data got %h want 07", rx_data1); end
    vectors++; if (perr1 !== 1'b1) begin errors++; $display("FAIL bad_par_err got %b want 1", perr1); end
    rx_ready1 = 1'b1; @(negedge clock); rx_ready1 = 1'b0;
  endtask

  task automatic test_glitch;
    line0 = 1'b0; repeat (4) @(negedge clock);
    line0 = 1'b1; repeat (40) @(negedge clock);
    vectors++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", rx_valid0); end
    send_rx(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    vectors++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL glitch_next_valid got %b want 1", rx_valid0); end
    vectors++; if (rx_data0 !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h want 3c", rx_data0); end
    vectors++; if ({perr0, ferr0} !== 2'b00) begin errors++; $display("FAIL glitch_next_errs got %b want 00", {perr0, ferr0}); end
    rx_ready0 = 1'b1; @(negedge clock); rx_ready0 = 1'b0;
    vectors++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL glitch_consume got %b want 0", rx_valid0); end
  endtask

  task automatic test_frame_err;
    send_rx(0, 8'h55, 1'b0, 1'b0, 1'b0);
    vectors++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL ferr_valid got %b want 1", rx_valid0); end
    vectors++; if (rx_data0 !== 8'h55) begin errors++; $display("FAIL ferr_data got %h want 55", rx_data0); end
    vectors++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", ferr0); end
    rx_ready0 = 1'b1; @(negedge clock); rx_ready0 = 1'b0;
    repeat (16) @(negedge clock);
  endtask

  task automatic test_overrun;
    int base;
    base = ovr_cnt;
    send_rx(0, 8'h11, 1'b0, 1'b0, 1'b1);
    vectors++; if (ovr_cnt - base !== 0) begin errors++; $display("FAIL ovr_early got %0d want 0", ovr_cnt - base); end
    send_rx(0, 8'h22, 1'b0, 1'b0, 1'b1);
    vectors++; if (ovr_cnt - base !== 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - base); end
    vectors++; if (rx_data0 !== 8'h11) begin errors++; $display("FAIL ovr_held_data got %h want 11", rx_data0); end
    vectors++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", rx_valid0); end
    vectors++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL ovr_ferr got %b want 0", ferr0); end
    rx_ready0 = 1'b1; @(negedge clock); rx_ready0 = 1'b0;
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] d;
    logic       exp_line;
    tx_data0 = 8'h00; tx_valid0 = 1'b1;
    @(negedge clock);
    tx_valid0 = 1'b0;
    for (int k = 1; k < 50; k++) @(negedge clock);
    vectors++; if (stx0 !== 1'b0) begin errors++; $display("FAIL mid_tx_line got %b want 0", stx0); end
    reset = 1'b1;
    @(negedge clock);
    vectors++; if (stx0 !== 1'b1) begin errors++; $display("FAIL mid_reset_line got %b want 1", stx0); end
    vectors++; if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", tx_ready0); end
    reset = 1'b0;
    @(negedge clock);
    d = 8'h81;
    tx_data0 = d; tx_valid0 = 1'b1;
    @(negedge clock);
    tx_valid0 = 1'b0;
    for (int k = 1; k <= 161; k++) begin
      if (k % 16 == 8) begin
        exp_line = (k < 16) ? 1'b0 : (k < 144) ? d[(k - 17) / 16] : 1'b1;
        vectors++;
        if (stx0 !== exp_line) begin errors++; $display("FAIL post_reset_tx clk %0d got %b want %b", k, stx0, exp_line); end
      end
      if (k >= 160) begin
        vectors++;
        if (tx_ready0 !== (k == 161)) begin errors++; $display("FAIL post_reset_ready clk %0d got %b want %b", k, tx_ready0, k == 161); end
      end
      if (k < 161) @(negedge clock);
    end
  endtask

  initial begin
    test_reset;
    test_tx_8n1;
    test_parity_loopback;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_mid_tx;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_framed.md
UART_FRAMED -- requirements
Module: uart_framed

Interface
REQ-001 Param CLOCK_HZ, default 1_000_000, input clock frequency in Hz.
REQ-002 Param BAUD_HZ, default 9_600, line bit rate in Hz.
REQ-003 Param DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-004 Param PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Param STOP_BITS, default 1, stop bits transmitted; legal values 1 or 2.
REQ-006 Port clock, input, 1, sole clock; all logic on posedge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port tx_data, input, DATA_BITS, byte to transmit.
REQ-009 Port tx_valid, input, 1, tx_data offered.
REQ-010 Port tx_ready, output, 1, transmitter can accept.
REQ-011 Port serial_tx, output, 1, line output, idle high.
REQ-012 Port serial_rx, input, 1, asynchronous line input.
REQ-013 Port rx_data, output, DATA_BITS, received payload.
REQ-014 Port rx_valid, output, 1, rx_data holds an unconsumed frame.
REQ-015 Port rx_ready, input, 1, consumer accepts rx_data.
REQ-016 Port rx_parity_err, output, 1, parity mismatch on the frame in rx_data; always 0 when PARITY=0.
REQ-017 Port rx_frame_err, output, 1, first stop bit sampled low on the frame in rx_data.
REQ-018 Port rx_overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-019 OS_DIV = CLOCK_HZ/(16*BAUD_HZ) (integer division); BIT_CLKS = 16*OS_DIV; OS_DIV<1 or an illegal parameter value is an elaboration error.
REQ-020 TX handshake completes in a cycle with tx_valid && tx_ready; tx_data is captured then; tx_ready is high only in TX state IDLE.
REQ-021 TX FSM IDLE->START->DATA->PARITY (only if PARITY!=0)->STOP->IDLE; each bit, including each stop bit, lasts exactly BIT_CLKS clocks.
REQ-022 serial_tx goes low the cycle after the handshake; data goes out LSB first; parity bit makes the count of ones even (mode 1) or odd (mode 2) across data+parity.
REQ-023 tx_ready rises the cycle after the last stop bit ends; back-to-back frames therefore have no idle gap beyond one cycle.
REQ-024 serial_rx passes through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-025 RX FSM IDLE->START->DATA->PARITY (if enabled)->STOP->IDLE; a falling edge of synchronized rx in IDLE enters START and restarts the oversample tick.
REQ-026 RX samples each bit at oversample count 7 (mid-bit); START sampled high returns to IDLE with no output (glitch reject).
REQ-027 RX checks only the first stop bit, returns to IDLE right after that sample, and can accept a new start edge on the next cycle.
REQ-028 At frame completion with rx_valid=0, or in a cycle where rx_valid && rx_ready: rx_data, rx_parity_err and rx_frame_err load; rx_valid=1.
REQ-029 At frame completion with rx_valid && !rx_ready: the new frame is discarded, held data is unchanged, and rx_overrun pulses for 1 cycle.
REQ-030 rx_valid clears the cycle after rx_valid && rx_ready, unless REQ-028 reloads in that same cycle.

Reset
REQ-031 Reset outputs: serial_tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error/overrun outputs 0.
REQ-032 Both FSMs go to IDLE and all counters clear; assertion mid-frame aborts TX and RX in that cycle.

Structure
REQ-033 Parity mode encodings, FSM state encodings and the OS_DIV/BIT_CLKS derivation belong in the shared package uart_pkg.
REQ-034 Sub-module uart_baud_gen (restart input, one-cycle tick every OS_DIV clocks); TX and RX each instantiate one.

Verification
Bench overrides: CLOCK_HZ=16_000_000, BAUD_HZ=1_000_000 (OS_DIV=1, BIT_CLKS=16).
REQ-035 TX 8N1, 0xA5 -> serial_tx low 16 clks from the cycle after the handshake, then data 1,0,1,0,0,1,0,1 (16 clks each), then high; tx_ready high 161 clks after the handshake.
REQ-036 Loopback, PARITY=1, 0x07 -> TX parity bit 1; rx_data=0x07, rx_valid=1, rx_parity_err=0; with the parity bit forced to 0 -> rx_parity_err=1.
REQ-037 serial_rx low for 4 clks then high -> no rx_valid; the next valid frame 0x3C is received correctly.
REQ-038 Frame 0x55 with stop bit driven low -> rx_valid=1, rx_data=0x55, rx_frame_err=1.
REQ-039 Frames 0x11 then 0x22, rx_ready held 0 -> rx_data stays 0x11, one rx_overrun pulse at end of the 0x22 frame.
REQ-040 Reset asserted 50 clks into a TX frame -> next cycle serial_tx=1, tx_ready=1; a new handshake then sends a full frame.
